// File: rtl/ballot_unit.sv
// Voter console: conditions the candidate/confirm buttons and ballot handshakes,
// then emits exactly one 4-bit candidate code per issued ballot over valid/ack.
module ballot_unit #(
   parameter int DEB_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ballot_en,
   input  logic        close,
   input  logic [14:0] btn,
   input  logic        confirm,
   input  logic        vote_ack,
   output logic        vote_valid,
   output logic [3:0]  vote_code,
   output logic        ready_led,
   output logic [3:0]  sel_code,
   output logic        multi_err,
   output logic        timeout
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_SELECTED,
      S_SEND,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------------
   // Synchronisers: {vote_ack, ballot_en, confirm, btn[14:0]}
   // ---------------------------------------------------------------------
   logic [17:0] sync1_q, sync2_q;
   logic [15:0] samp_vec;
   logic        en_s, ack_s;

   // NOTE: every clocked process uses non-blocking (<=) so all flops sample
   // pre-edge values; blocking here would chain the two sync stages into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {vote_ack, ballot_en, confirm, btn};
         sync2_q <= sync1_q;
      end
   end

   assign samp_vec = sync2_q[15:0];
   assign en_s     = sync2_q[16];
   assign ack_s    = sync2_q[17];

   // ---------------------------------------------------------------------
   // Debouncer: deb_q follows the sample only after DEB_CYCLES equal samples
   // ---------------------------------------------------------------------
   logic [15:0]      samp_q, deb_q;
   logic [DEB_W-1:0] deb_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q    <= '0;
         deb_q     <= '0;
         deb_cnt_q <= '0;
      end else if (samp_vec != samp_q) begin
         samp_q    <= samp_vec;
         deb_cnt_q <= DEB_W'(1);
      end else if (deb_cnt_q < DEB_LAST) begin
         deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end else begin
         deb_q <= samp_q;
      end
   end

   logic [14:0] btn_deb;
   logic        conf_deb;
   logic        btn_any, btn_one, btn_multi;
   logic [3:0]  btn_code;

   assign btn_deb   = deb_q[14:0];
   assign conf_deb  = deb_q[15];
   assign btn_any   = |btn_deb;
   assign btn_one   = btn_any && ((btn_deb & (btn_deb - 15'd1)) == 15'd0);
   assign btn_multi = btn_any && !btn_one;

   // NOTE: combinational blocks assign every output a default first, so no
   // path can leave a variable unassigned and infer a latch.
   always_comb begin
      btn_code = 4'd0;
      for (int i = 0; i < 15; i++) begin
         if (btn_deb[i]) btn_code = 4'(i + 1);
      end
   end

   // ---------------------------------------------------------------------
   // Edge history for ballot issue, confirm and multi-press
   // ---------------------------------------------------------------------
   logic en_prev_q, conf_prev_q, multi_prev_q;
   logic en_rise, conf_rise, multi_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_prev_q    <= 1'b0;
         conf_prev_q  <= 1'b0;
         multi_prev_q <= 1'b0;
      end else begin
         en_prev_q    <= en_s;
         conf_prev_q  <= conf_deb;
         multi_prev_q <= btn_multi;
      end
   end

   assign en_rise    = en_s && !en_prev_q;
   assign conf_rise  = conf_deb && !conf_prev_q;
   assign multi_rise = btn_multi && !multi_prev_q;

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   state_t           state_q, state_nx;
   logic [3:0]       code_q, code_nx;
   logic [CNT_W-1:0] cnt_q;
   logic             cnt_clr, cnt_inc, multi_pulse, tmo_pulse;

   always_comb begin
      state_nx    = state_q;
      code_nx     = code_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      multi_pulse = 1'b0;
      tmo_pulse   = 1'b0;
      case (state_q)
         S_IDLE: begin
            code_nx = 4'd0;
            if (en_rise && !close) begin
               state_nx = S_ARMED;
               cnt_clr  = 1'b1;
            end
         end
         S_ARMED, S_SELECTED: begin
            cnt_inc = 1'b1;
            // close outranks timeout so a closing poll never reports a timeout
            if (close) begin
               state_nx = S_IDLE;
               code_nx  = 4'd0;
            end else if (cnt_q == TMO_LAST) begin
               state_nx  = S_IDLE;
               code_nx   = 4'd0;
               tmo_pulse = 1'b1;
            end else if (btn_one && (btn_code != code_q)) begin
               state_nx = S_SELECTED;
               code_nx  = btn_code;
               cnt_clr  = 1'b1;
            end else if (multi_rise) begin
               multi_pulse = 1'b1;
            end else if ((state_q == S_SELECTED) && conf_rise && !btn_any) begin
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            if (ack_s) state_nx = S_DONE;
         end
         S_DONE: begin
            code_nx = 4'd0;
            if ((deb_q == 16'd0) && !ack_s) state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
            code_nx  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         code_q  <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nx;
         code_q  <= code_nx;
         if (cnt_clr) begin
            cnt_q <= '0;
         end else if (cnt_inc && (cnt_q != TMO_LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Outputs are registered from the next state so they are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vote_valid <= 1'b0;
         vote_code  <= 4'd0;
         ready_led  <= 1'b0;
         sel_code   <= 4'd0;
         multi_err  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         vote_valid <= (state_nx == S_SEND);
         vote_code  <= (state_nx == S_SEND) ? code_nx : 4'd0;
         ready_led  <= (state_nx == S_ARMED) || (state_nx == S_SELECTED);
         sel_code   <= ((state_nx == S_SELECTED) || (state_nx == S_SEND)) ? code_nx : 4'd0;
         multi_err  <= multi_pulse;
         timeout    <= tmo_pulse;
      end
   end

endmodule
